// File: rtl/capture_sequencer.sv
// capture_sequencer: decodes host commands into capture-datapath strobes and
// maintains the polled response word for the logic-analyzer instrument.
module capture_sequencer #(
    parameter int          NUM_BUFS  = 4,
    parameter int          BUF_IDX_W = 2,
    parameter logic [31:0] ID_VALUE  = 32'h534C_0001
) (
    input  logic                 inclk,
    input  logic                 Reset_n,
    input  logic                 cmd_valid,
    input  logic [7:0]           cmd,
    input  logic [31:0]          wr_data,
    input  logic                 buf_full,
    output logic [31:0]          resp,
    output logic                 sys_clear,
    output logic                 fifo_init,
    output logic                 cfg_we,
    output logic [2:0]           cfg_addr,
    output logic [31:0]          cfg_data,
    output logic                 acq_en,
    output logic                 buf_next,
    output logic [BUF_IDX_W-1:0] buf_idx,
    output logic                 cmd_err
);
    typedef enum logic [2:0] {IDLE, ARMED, WAITING, FILL, DONE} state_t;
    state_t state, state_d;
    logic pend_full, pend_d;
    logic legal, accept, capturing, event_hit, last_buf;
    logic [31:0] resp_d, cfg_data_d;
    logic [2:0] cfg_addr_d;
    logic acq_d;
    logic [BUF_IDX_W-1:0] idx_d;
    logic clear_d, init_d, we_d, next_d, err_d;
    assign capturing = state == ARMED || state == FILL;
    assign last_buf  = buf_idx == BUF_IDX_W'(NUM_BUFS - 1);
    assign legal = cmd == 8'd0 || cmd == 8'd2 || cmd == 8'd6
                || (cmd == 8'd4 && state == WAITING)
                || (cmd == 8'd5 && (capturing || state == WAITING))
                || (state == IDLE && (cmd == 8'd1 || cmd == 8'd3 || (cmd >= 8'd7 && cmd <= 8'd14)));
    assign accept = cmd_valid && legal;
    // A pending or live buf_full only acts when no command claims the cycle.
    assign event_hit = !accept && capturing && (buf_full || pend_full);
    always_ff @(posedge inclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            resp      <= '0;
            acq_en    <= 1'b0;
            buf_idx   <= '0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            sys_clear <= 1'b0;
            fifo_init <= 1'b0;
            cfg_we    <= 1'b0;
            buf_next  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_d;
            pend_full <= pend_d;
            resp      <= resp_d;
            acq_en    <= acq_d;
            buf_idx   <= idx_d;
            cfg_addr  <= cfg_addr_d;
            cfg_data  <= cfg_data_d;
            sys_clear <= clear_d;
            fifo_init <= init_d;
            cfg_we    <= we_d;
            buf_next  <= next_d;
            cmd_err   <= err_d;
        end
    end
    always_comb begin
        state_d = state;
        pend_d  = pend_full;
        if (accept) begin
            case (cmd)
                8'd0, 8'd2: state_d = IDLE;
                8'd3:       state_d = ARMED;
                8'd4:       state_d = last_buf ? DONE : FILL;
                8'd5:       state_d = DONE;
                default:    state_d = state;
            endcase
            // Only CMD_ID keeps the capture alive, so only it can defer a buf_full.
            pend_d = cmd == 8'd6 && (pend_full || (buf_full && capturing));
        end else if (event_hit) begin
            state_d = WAITING;
            pend_d  = 1'b0;
        end
    end
    always_comb begin
        resp_d     = resp;
        acq_d      = acq_en;
        idx_d      = buf_idx;
        cfg_addr_d = cfg_addr;
        cfg_data_d = cfg_data;
        clear_d    = accept && cmd == 8'd0;
        init_d     = accept && cmd == 8'd1;
        we_d       = accept && cmd >= 8'd7;
        next_d     = accept && cmd == 8'd4;
        err_d      = cmd_valid && !legal;
        if (accept) begin
            case (cmd)
                8'd0: begin
                    resp_d = '0;
                    acq_d  = 1'b0;
                    idx_d  = '0;
                end
                8'd1: resp_d = 32'd1;
                8'd2: begin
                    resp_d = 32'd2;
                    acq_d  = 1'b0;
                end
                8'd3: begin
                    resp_d = 32'd3;
                    acq_d  = 1'b1;
                    idx_d  = '0;
                end
                8'd4: begin
                    resp_d = last_buf ? 32'd6 : 32'd4;
                    acq_d  = !last_buf;
                    idx_d  = last_buf ? buf_idx : buf_idx + BUF_IDX_W'(1);
                end
                8'd5: begin
                    resp_d = 32'd6;
                    acq_d  = 1'b0;
                end
                8'd6: resp_d = ID_VALUE;
                default: begin
                    resp_d     = {24'd0, cmd};
                    cfg_addr_d = 3'(cmd - 8'd7);
                    cfg_data_d = wr_data;
                end
            endcase
        end else if (event_hit) begin
            resp_d = 32'd5;
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: scoreboard bench comparing the sequencer against a reference model
module tb_capture_sequencer;
  localparam int          NUM_BUFS  = 4;
  localparam int          BUF_IDX_W = 2;
  localparam logic [31:0] ID_VALUE  = 32'h534C_0001;
  localparam int M_IDLE = 0, M_ARMED = 1, M_WAITING = 2, M_FILL = 3, M_DONE = 4;
  logic inclk, Reset_n, cmd_valid, buf_full;
  logic [7:0] cmd;
  logic [31:0] wr_data, resp, cfg_data;
  logic sys_clear, fifo_init, cfg_we, acq_en, buf_next, cmd_err;
  logic [2:0] cfg_addr;
  logic [BUF_IDX_W-1:0] buf_idx;
  capture_sequencer #(.NUM_BUFS(NUM_BUFS), .BUF_IDX_W(BUF_IDX_W), .ID_VALUE(ID_VALUE)) dut (
    .inclk(inclk), .Reset_n(Reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .wr_data(wr_data),
    .buf_full(buf_full), .resp(resp), .sys_clear(sys_clear), .fifo_init(fifo_init),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .acq_en(acq_en),
    .buf_next(buf_next), .buf_idx(buf_idx), .cmd_err(cmd_err)
  );
  logic [74:0] out_vec;
  assign out_vec = {resp, acq_en, buf_idx, cfg_addr, cfg_data, sys_clear, fifo_init, cfg_we, buf_next, cmd_err};
  initial inclk = 1'b0;
  always #5 inclk = ~inclk;
  int checks = 0, errors = 0;
  logic [74:0] exp_q[$];
  logic [74:0] async_q[$];
  event chk_ev;
  int mode, m_idx;
  bit m_pend, p_clear, p_init, p_we, p_next, p_err;
  logic [31:0] m_resp, m_cfg_data;
  logic [2:0] m_cfg_addr;
  function automatic bit allowed(int c, int md);
    if (c == 0 || c == 2 || c == 6) return 1'b1;
    if (c == 4) return md == M_WAITING;
    if (c == 5) return md == M_ARMED || md == M_WAITING || md == M_FILL;
    if (c == 1 || c == 3 || (c >= 7 && c <= 14)) return md == M_IDLE;
    return 1'b0;
  endfunction
  function automatic logic [74:0] exp_vec();
    bit acq;
    acq = mode == M_ARMED || mode == M_WAITING || mode == M_FILL;
    return {m_resp, acq, BUF_IDX_W'(m_idx), m_cfg_addr, m_cfg_data, p_clear, p_init, p_we, p_next, p_err};
  endfunction
  task automatic model_reset();
    mode = M_IDLE; m_idx = 0; m_pend = 0; m_resp = 0; m_cfg_addr = 0; m_cfg_data = 0;
    {p_clear, p_init, p_we, p_next, p_err} = 5'b0;
  endtask
  task automatic model_step(input bit v, input int c, input logic [31:0] w, input bit bf);
    bit ok, capt;
    {p_clear, p_init, p_we, p_next, p_err} = 5'b0;
    capt = mode == M_ARMED || mode == M_FILL;
    ok = v && allowed(c, mode);
    p_err = v && !ok;
    if (ok) begin
      if (c == 6 && bf && capt) m_pend = 1;
      case (c)
        0: begin p_clear = 1; mode = M_IDLE; m_idx = 0; m_resp = 0; m_pend = 0; end
        1: begin p_init = 1; m_resp = 1; end
        2: begin mode = M_IDLE; m_resp = 2; m_pend = 0; end
        3: begin mode = M_ARMED; m_idx = 0; m_resp = 3; end
        4: begin
          p_next = 1;
          if (m_idx == NUM_BUFS - 1) begin mode = M_DONE; m_resp = 6; end
          else begin m_idx++; mode = M_FILL; m_resp = 4; end
        end
        5: begin mode = M_DONE; m_resp = 6; m_pend = 0; end
        6: m_resp = ID_VALUE;
        default: begin p_we = 1; m_cfg_addr = 3'(c - 7); m_cfg_data = w; m_resp = 32'(c); end
      endcase
    end else if (capt && (bf || m_pend)) begin
      mode = M_WAITING; m_resp = 5; m_pend = 0;
    end
    if (mode == M_DONE) m_pend = 0;
  endtask
  task automatic cyc(input bit v, input logic [7:0] c, input logic [31:0] w, input bit bf);
    @(negedge inclk);
    Reset_n = 1; cmd_valid = v; cmd = c; wr_data = w; buf_full = bf;
    model_step(v, int'(c), w, bf);
    exp_q.push_back(exp_vec());
  endtask
  task automatic rst_cyc();
    @(negedge inclk);
    Reset_n = 0; cmd_valid = 0; buf_full = 0;
    model_reset();
    exp_q.push_back(exp_vec());
  endtask
  task automatic async_rst();
    @(negedge inclk);
    Reset_n = 0; cmd_valid = 0; buf_full = 0;
    model_reset();
    async_q.push_back(exp_vec());
    -> chk_ev;
    exp_q.push_back(exp_vec());
  endtask
  initial begin
    logic [74:0] e;
    forever begin
      @(posedge inclk or chk_ev);
      #1;
      if (async_q.size() > 0) begin
        e = async_q.pop_front();
        checks++;
        if (out_vec !== e) begin
          errors++;
          $display("FAIL async_reset t=%0t got %h exp %h", $time, out_vec, e);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_vec !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got %h exp %h", $time, out_vec, e);
        end
      end
    end
  end
  logic [7:0] picks [20] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd5, 8'd6,
                             8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'hFF};
  initial begin
    Reset_n = 0; cmd_valid = 0; cmd = 0; wr_data = 0; buf_full = 0;
    model_reset();
    rst_cyc(); rst_cyc();
    cyc(1, 8'd1, 0, 0);
    cyc(1, 8'd9, 32'h0003_0000, 0);
    cyc(0, 8'd0, 0, 0);
    cyc(1, 8'd3, 0, 0);
    cyc(1, 8'd9, 32'h1234_5678, 0);
    cyc(0, 8'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'd4, 0, 0);
      cyc(0, 8'd0, 0, 1);
    end
    cyc(1, 8'd4, 0, 0);
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd6, 0, 0);
    cyc(1, 8'd0, 0, 0);
    cyc(1, 8'd3, 0, 0);
    cyc(1, 8'd6, 0, 1);
    cyc(0, 8'd0, 0, 0);
    cyc(1, 8'd4, 0, 0);
    cyc(1, 8'd5, 0, 0);
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd5, 0, 0);
    cyc(1, 8'd0, 0, 0);
    cyc(1, 8'd3, 0, 0);
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd4, 0, 0);
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd4, 0, 0);
    cyc(0, 8'd0, 0, 1);
    async_rst();
    rst_cyc();
    cyc(1, 8'd15, 0, 0);
    cyc(1, 8'hFF, 0, 0);
    cyc(1, 8'd14, 32'hDEAD_BEEF, 0);
    cyc(1, 8'd7, 32'h0000_00A5, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_rst();
        rst_cyc();
      end else begin
        cyc($urandom_range(0, 1) == 1, picks[$urandom_range(0, 19)], $urandom,
            $urandom_range(0, 99) < 35);
      end
    end
    cyc(0, 8'd0, 0, 0);
    @(posedge inclk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
